// File: rtl/vcmp_pkg.sv
// Shared definitions for the vector mask-compare path: SEW encoding, compare
// opcodes, sequencer states and the elements-per-beat helper.
package vcmp_pkg;

  localparam logic [1:0] SEW_E8  = 2'd0;
  localparam logic [1:0] SEW_E16 = 2'd1;
  localparam logic [1:0] SEW_E32 = 2'd2;
  localparam logic [1:0] SEW_E64 = 2'd3;

  typedef enum logic [2:0] {
    OP_EQ  = 3'd0,
    OP_NE  = 3'd1,
    OP_LTU = 3'd2,
    OP_LT  = 3'd3,
    OP_LEU = 3'd4,
    OP_LE  = 3'd5,
    OP_GTU = 3'd6,
    OP_GT  = 3'd7
  } opsel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  function automatic int unsigned epb(input logic [1:0] sew, input int unsigned data_width);
    return data_width >> (3 + int'(sew));
  endfunction

endpackage

// File: rtl/vmcmp_seq_if.sv
// Command, register-file read and compare-unit beat signals of the sequencer.
// The issue stage / register file side is master, the sequencer is slave.
interface vmcmp_seq_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int SEW_WIDTH   = 2,
  parameter int OPSEL_WIDTH = 3,
  parameter int VL_WIDTH    = 11
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [VL_WIDTH-1:0]    cmd_vl;
  logic [SEW_WIDTH-1:0]   cmd_sew;
  logic [OPSEL_WIDTH-1:0] cmd_opsel;
  logic [ADDR_WIDTH-1:0]  cmd_vs1;
  logic [ADDR_WIDTH-1:0]  cmd_vs2;
  logic [ADDR_WIDTH-1:0]  cmd_vd;
  logic                   rd_req;
  logic                   rd_gnt;
  logic [ADDR_WIDTH-1:0]  rd_addr0;
  logic [ADDR_WIDTH-1:0]  rd_addr1;
  logic [DATA_WIDTH-1:0]  rd_data0;
  logic [DATA_WIDTH-1:0]  rd_data1;
  logic                   cu_valid;
  logic [DATA_WIDTH-1:0]  cu_vec0;
  logic [DATA_WIDTH-1:0]  cu_vec1;
  logic [SEW_WIDTH-1:0]   cu_sew;
  logic [OPSEL_WIDTH-1:0] cu_opsel;
  logic [ADDR_WIDTH-1:0]  cu_addr;
  logic [7:0]             cu_start_idx;
  logic                   cu_req_start;
  logic                   cu_req_end;
  logic                   busy;
  logic                   done;

  modport master (
    output cmd_valid, cmd_vl, cmd_sew, cmd_opsel, cmd_vs1, cmd_vs2, cmd_vd,
    output rd_gnt, rd_data0, rd_data1,
    input  cmd_ready, rd_req, rd_addr0, rd_addr1,
    input  cu_valid, cu_vec0, cu_vec1, cu_sew, cu_opsel, cu_addr, cu_start_idx,
    input  cu_req_start, cu_req_end, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_vl, cmd_sew, cmd_opsel, cmd_vs1, cmd_vs2, cmd_vd,
    input  rd_gnt, rd_data0, rd_data1,
    output cmd_ready, rd_req, rd_addr0, rd_addr1,
    output cu_valid, cu_vec0, cu_vec1, cu_sew, cu_opsel, cu_addr, cu_start_idx,
    output cu_req_start, cu_req_end, busy, done
  );
endinterface

// File: rtl/vmcmp_beat_gen.sv
// Beat framing for one compare command: destination mask word, bit offset of
// the beat's first element, and first/last beat flags.
module vmcmp_beat_gen
  import vcmp_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int SEW_WIDTH  = 2,
  parameter int VL_WIDTH   = 11
) (
  input  logic [VL_WIDTH-1:0]   vl,
  input  logic [SEW_WIDTH-1:0]  sew,
  input  logic [ADDR_WIDTH-1:0] vd,
  input  logic [VL_WIDTH-1:0]   beat_idx,
  output logic [ADDR_WIDTH-1:0] cu_addr,
  output logic [7:0]            cu_start_idx,
  output logic                  req_start,
  output logic                  req_end,
  output logic                  last_beat
);
  localparam int LOG2_DW = $clog2(DATA_WIDTH);
  localparam int EW      = VL_WIDTH + 1;

  int unsigned   sh;
  logic [EW-1:0] epb_w;
  logic [EW-1:0] beats;
  logic [EW-1:0] elem_idx;

  // epb is a power of two, so beat counts and element offsets are shifts
  always_comb begin
    sh           = LOG2_DW - 3 - int'(sew);
    epb_w        = EW'(epb(2'(sew), DATA_WIDTH));
    beats        = (EW'(vl) + epb_w - EW'(1)) >> sh;
    elem_idx     = EW'(beat_idx) << sh;
    cu_addr      = vd + ADDR_WIDTH'(elem_idx >> LOG2_DW);
    cu_start_idx = 8'(elem_idx & EW'(DATA_WIDTH - 1));
    req_start    = (beat_idx == '0);
    last_beat    = (EW'(beat_idx) == beats - EW'(1));
    req_end      = last_beat;
  end

endmodule

// File: rtl/vmcmp_seq.sv
// Mask-compare sequencer: reads operand beats over a request/grant port,
// frames them for the compare unit, drains its fixed latency, pulses done.
module vmcmp_seq
  import vcmp_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int SEW_WIDTH   = 2,
  parameter int OPSEL_WIDTH = 3,
  parameter int VL_WIDTH    = 11,
  parameter int CU_LATENCY  = 6
) (
  input logic        clk,
  input logic        rst,
  vmcmp_seq_if.slave bus
);
  localparam int DCW = $clog2(CU_LATENCY + 1);

  seq_state_e             state, state_nxt;
  logic                   cmd_ready, rd_req, cmd_fire, gnt, all_gnt;
  logic [VL_WIDTH-1:0]    vl_q, beat_idx;
  logic [SEW_WIDTH-1:0]   sew_q;
  logic [OPSEL_WIDTH-1:0] opsel_q;
  logic [ADDR_WIDTH-1:0]  vs1_q, vs2_q, vd_q;
  logic [DCW-1:0]         drain_cnt;

  logic [ADDR_WIDTH-1:0]  bg_addr;
  logic [7:0]             bg_idx;
  logic                   bg_start, bg_end, bg_last;

  logic                   vld_p1, start_p1, end_p1;
  logic [ADDR_WIDTH-1:0]  addr_p1;
  logic [7:0]             idx_p1;
  logic [SEW_WIDTH-1:0]   sew_p1;
  logic [OPSEL_WIDTH-1:0] opsel_p1;
  logic [DATA_WIDTH-1:0]  vec0_hold, vec1_hold;

  assign cmd_fire = bus.cmd_valid & cmd_ready;
  assign gnt      = rd_req & bus.rd_gnt;

  vmcmp_beat_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .SEW_WIDTH (SEW_WIDTH),
    .VL_WIDTH  (VL_WIDTH)
  ) u_beat_gen (
    .vl          (vl_q),
    .sew         (sew_q),
    .vd          (vd_q),
    .beat_idx    (beat_idx),
    .cu_addr     (bg_addr),
    .cu_start_idx(bg_idx),
    .req_start   (bg_start),
    .req_end     (bg_end),
    .last_beat   (bg_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // DONE is entered one cycle before the drain counter would reach zero so
  // that done lands CU_LATENCY+1 cycles after the last beat
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rd_req    = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_nxt = (bus.cmd_vl == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        rd_req = !all_gnt;
        if (vld_p1 && end_p1) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (drain_cnt <= DCW'(1)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vl_q      <= '0;
      sew_q     <= '0;
      opsel_q   <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vd_q      <= '0;
      beat_idx  <= '0;
      all_gnt   <= 1'b0;
      drain_cnt <= '0;
      vld_p1    <= 1'b0;
      start_p1  <= 1'b0;
      end_p1    <= 1'b0;
      addr_p1   <= '0;
      idx_p1    <= '0;
      sew_p1    <= '0;
      opsel_p1  <= '0;
      vec0_hold <= '0;
      vec1_hold <= '0;
    end else begin
      if (cmd_fire) begin
        vl_q     <= bus.cmd_vl;
        sew_q    <= bus.cmd_sew;
        opsel_q  <= bus.cmd_opsel;
        vs1_q    <= bus.cmd_vs1;
        vs2_q    <= bus.cmd_vs2;
        vd_q     <= bus.cmd_vd;
        beat_idx <= '0;
        all_gnt  <= 1'b0;
      end
      if (gnt) begin
        beat_idx <= beat_idx + VL_WIDTH'(1);
        if (bg_last) all_gnt <= 1'b1;
      end
      if (state == ST_ISSUE && state_nxt == ST_DRAIN) drain_cnt <= DCW'(CU_LATENCY);
      else if (state == ST_DRAIN && drain_cnt != '0)  drain_cnt <= drain_cnt - DCW'(1);

      // p1: beat framing captured at grant, aligned with the read data
      vld_p1   <= gnt;
      start_p1 <= gnt & bg_start;
      end_p1   <= gnt & bg_end;
      if (gnt) begin
        addr_p1  <= bg_addr;
        idx_p1   <= bg_idx;
        sew_p1   <= sew_q;
        opsel_p1 <= opsel_q;
      end
      if (vld_p1) begin
        vec0_hold <= bus.rd_data0;
        vec1_hold <= bus.rd_data1;
      end
    end
  end

  assign bus.cmd_ready    = cmd_ready;
  assign bus.rd_req       = rd_req;
  assign bus.rd_addr0     = vs1_q + ADDR_WIDTH'(beat_idx);
  assign bus.rd_addr1     = vs2_q + ADDR_WIDTH'(beat_idx);
  assign bus.cu_valid     = vld_p1;
  assign bus.cu_vec0      = vld_p1 ? bus.rd_data0 : vec0_hold;
  assign bus.cu_vec1      = vld_p1 ? bus.rd_data1 : vec1_hold;
  assign bus.cu_sew       = sew_p1;
  assign bus.cu_opsel     = opsel_p1;
  assign bus.cu_addr      = addr_p1;
  assign bus.cu_start_idx = idx_p1;
  assign bus.cu_req_start = start_p1;
  assign bus.cu_req_end   = end_p1;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.done         = (state == ST_DONE);

endmodule
